laser_pair_select: RTL
======================

# laser_pair_select

Downstream stage of the laser point-cover builder. It takes the 40-point cover masks of all 256 candidate circle centres and picks two centres that together cover as many points as it can. Selection is greedy, followed by alternating refinement. The block reads masks one row per cycle through a synchronous read port. It drives the final C1/C2 coordinates and DONE to the top level.

## Interface
Parameters:
- NPTS, 40: points per mask (mask width).
- MAX_PASS, 6: maximum scan passes per run (minimum legal value 2).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a run; ignored while BUSY=1.
- MASK_ADDR  out  8  candidate index being read; bits [3:0]=x, bits [7:4]=y.
- MASK_DATA  in  NPTS  cover mask of the candidate; valid exactly one cycle after MASK_ADDR (registered read); bit k=1 means point k is covered.
- C1X, C1Y, C2X, C2Y  out  4 each  selected centres (slot A → C1, slot B → C2).
- COVER_CNT  out  6  points covered by the union of both selected circles.
- BUSY  out  1  high from the cycle after START is accepted until DONE rises.
- DONE  out  1  high after a run completes; held until the next accepted START.

## Operation
- States: IDLE, SCAN, EVAL, FIN.
- On START in IDLE: clear DONE, set BUSY, set pass=0, go to SCAN.
- SCAN:
  - MASK_ADDR steps 0..255, one per cycle.
  - For each returned row: score = popcount(MASK_DATA & ~EXCL), 6-bit.
  - Running best (score, index, mask) starts at (0, 0, 0).
  - The best is replaced only when score > best score (strict), so ties keep the lowest index.
- EXCL per pass:
  - Pass 0: EXCL=0; picks slot A.
  - Pass 1: EXCL = mask of A; picks slot B.
  - Pass p≥2, p even: EXCL = mask of B; re-picks A.
  - Pass p≥2, p odd: EXCL = mask of A; re-picks B.
- EVAL (one cycle after the last row is consumed):
  - Candidate total = popcount(EXCL) + best score.
  - Pass 0: store A, go to SCAN.
  - Pass 1: store B and TOTAL, go to SCAN.
  - Pass p≥2, candidate total > TOTAL: replace the re-picked slot (index and mask) and update TOTAL.
  - Pass p≥2, candidate total ≤ TOTAL: discard the result and go to FIN.
  - Also go to FIN when p = MAX_PASS-1. Otherwise increment pass and go to SCAN.
- FIN: load C1X/C1Y from A, C2X/C2Y from B, COVER_CNT from TOTAL. Set DONE=1, BUSY=0, return to IDLE.
- Outputs C*, COVER_CNT hold their values from FIN until the next FIN or reset.
- A and B may be equal. When EXCL already covers every point, all scores are 0 and the pass picks index 0.
- All-zero masks are legal: result A=B=index 0, COVER_CNT=0.

## Timing
- Reset (RST low, asynchronous): state IDLE.
  - C1X, C1Y, C2X, C2Y, COVER_CNT, MASK_ADDR, BUSY, DONE = 0.
  - All internal registers cleared.
- START is sampled on a rising edge. MASK_ADDR=0 is driven in the following cycle.
- Each pass is 258 cycles: 256 address cycles, 1 read-latency cycle, 1 EVAL cycle.
- A run of P passes (2 ≤ P ≤ MAX_PASS, counting the final rejected pass) asserts DONE exactly 258·P+1 cycles after the START-sampling edge. The extra cycle is FIN.
- MASK_ADDR holds 255 during the latency and EVAL cycles. It returns to 0 at the start of the next SCAN.
- START asserted on the same edge DONE rises is ignored. START in IDLE with DONE=1 restarts the run.
- RST asserted mid-run aborts immediately. No partial result is driven. A new START is required after release.

## Test plan
- All 40 points at (5,5) → C1=(5,1), C2=(0,0), COVER_CNT=40. DONE at 258·3+1 cycles after START.
- 25 points at (2,2) and 15 at (12,12) → C1=(0,0), C2=(12,8), COVER_CNT=40, P=3.
- All masks zero → C1=C2=(0,0), COVER_CNT=0, DONE after 3 passes, BUSY low with DONE.
- Bench mask model where pass-2 re-pick of A strictly improves (e.g. first greedy choice overlaps B) → A replaced, TOTAL increases. Run ends on first non-improving pass or at pass MAX_PASS-1.
- RST pulled low during pass 1 → all outputs 0 immediately and no DONE. START after release → normal result.
- START re-pulsed while BUSY → ignored, cycle count unchanged. START after DONE → DONE drops next cycle, new run completes.

Source files
------------

// File: rtl/laser_pair_select.sv
// rtl/laser_pair_select.sv - picks two circle centres covering the most points
// Greedy two-pick followed by alternating re-picks of A and B until no improvement.
module laser_pair_select #(
   parameter int NPTS     = 40,
   parameter int MAX_PASS = 6
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   output logic [7:0]      MASK_ADDR,
   input  logic [NPTS-1:0] MASK_DATA,
   output logic [3:0]      C1X,
   output logic [3:0]      C1Y,
   output logic [3:0]      C2X,
   output logic [3:0]      C2Y,
   output logic [5:0]      COVER_CNT,
   output logic            BUSY,
   output logic            DONE
);

   localparam int PW = $clog2(MAX_PASS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_EVAL = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]      state;
   logic [8:0]      cyc;
   logic [PW-1:0]   pass;
   logic [5:0]      best_score;
   logic [7:0]      best_idx;
   logic [NPTS-1:0] best_mask;
   logic [7:0]      a_idx;
   logic [NPTS-1:0] a_mask;
   logic [7:0]      b_idx;
   logic [NPTS-1:0] b_mask;
   logic [5:0]      total;

   logic [NPTS-1:0] excl;
   logic [5:0]      score;
   logic [5:0]      cand_total;
   logic [7:0]      row_idx;
   logic            refine_pass;
   logic            improve;
   logic            last_pass;

   function automatic logic [5:0] popcnt(input logic [NPTS-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < NPTS; i++) begin
         c = c + 6'(v[i]);
      end
      return c;
   endfunction

   // Pass 0 excludes nothing; afterwards the slot not being re-picked is excluded.
   always_comb begin
      excl = '0;
      if (pass != '0) begin
         excl = pass[0] ? a_mask : b_mask;
      end
   end

   always_comb begin
      score       = popcnt(MASK_DATA & ~excl);
      cand_total  = popcnt(excl) + best_score;
      row_idx     = cyc[7:0] - 8'd1;
      refine_pass = (pass >= PW'(2));
      improve     = (cand_total > total);
      last_pass   = (pass == PW'(MAX_PASS - 1));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= S_IDLE;
         cyc        <= '0;
         pass       <= '0;
         best_score <= '0;
         best_idx   <= '0;
         best_mask  <= '0;
         a_idx      <= '0;
         a_mask     <= '0;
         b_idx      <= '0;
         b_mask     <= '0;
         total      <= '0;
         MASK_ADDR  <= '0;
         C1X        <= '0;
         C1Y        <= '0;
         C2X        <= '0;
         C2Y        <= '0;
         COVER_CNT  <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  DONE       <= 1'b0;
                  BUSY       <= 1'b1;
                  pass       <= '0;
                  cyc        <= '0;
                  MASK_ADDR  <= '0;
                  best_score <= '0;
                  best_idx   <= '0;
                  best_mask  <= '0;
                  state      <= S_SCAN;
               end
            end

            S_SCAN: begin
               // Data for the row addressed on cyc-1 arrives while cyc is 1..256.
               if ((cyc != 9'd0) && (score > best_score)) begin
                  best_score <= score;
                  best_idx   <= row_idx;
                  best_mask  <= MASK_DATA;
               end
               if (MASK_ADDR != 8'hFF) begin
                  MASK_ADDR <= MASK_ADDR + 8'd1;
               end
               cyc <= cyc + 9'd1;
               if (cyc == 9'd256) begin
                  state <= S_EVAL;
               end
            end

            S_EVAL: begin
               best_score <= '0;
               best_idx   <= '0;
               best_mask  <= '0;
               cyc        <= '0;
               if (pass == '0) begin
                  a_idx  <= best_idx;
                  a_mask <= best_mask;
               end else if (pass == PW'(1)) begin
                  b_idx  <= best_idx;
                  b_mask <= best_mask;
                  total  <= cand_total;
               end else if (improve) begin
                  if (!pass[0]) begin
                     a_idx  <= best_idx;
                     a_mask <= best_mask;
                  end else begin
                     b_idx  <= best_idx;
                     b_mask <= best_mask;
                  end
                  total <= cand_total;
               end

               if (last_pass || (refine_pass && !improve)) begin
                  state <= S_FIN;
               end else begin
                  pass      <= pass + PW'(1);
                  MASK_ADDR <= '0;
                  state     <= S_SCAN;
               end
            end

            S_FIN: begin
               C1X       <= a_idx[3:0];
               C1Y       <= a_idx[7:4];
               C2X       <= b_idx[3:0];
               C2Y       <= b_idx[7:4];
               COVER_CNT <= total;
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               state     <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
